// File: rtl/seven_seg_pkg.sv
// Shared segment patterns, scanner state encoding and the BCD-to-segment decode
// used by the multiplexed seven-segment display controller.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

  // Segment order is {a,b,c,d,e,f,g}; non-decimal codes render dark.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_segment.sv
// Combinational BCD-to-seven-segment decoder shared by all scanned digits.
module seven_segment
  import seven_seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_c_o
);

  assign seg_c_o = bcd_to_seg(bcd_i);

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-cathode display scanner with a double-buffered BCD word,
// per-slot anti-ghosting blanking and optional leading-zero suppression.
module seven_segment_scanner
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 1000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    lz_suppress,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int unsigned DATA_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  // With no guard cycles the blanking state is bypassed entirely.
  localparam state_e SLOT_START = (BLANK_CYCLES > 0) ? BLANK : DRIVE;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   pending_q, pending_d;
  logic                pend_v_q, pend_v_d;
  logic [DATA_W-1:0]   active_q, active_d;
  logic [6:0]          seg_q, seg_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
  logic                frame_done_q, frame_done_d;
  logic                load_ready_q, load_ready_d;

  logic                frame_end;
  logic                zero_above;
  logic                sel_blank;
  logic [3:0]          nib_sel;
  logic [6:0]          dec_seg;

  // Scan sequencing: slot counter runs across blank and drive phases of a slot.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    frame_end = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SLOT_START;
          cnt_d   = '0;
          idx_d   = '0;
        end
        BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) state_d = DRIVE;
        end
        DRIVE: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = SLOT_START;
            if (idx_q == IDX_LAST) begin
              idx_d     = '0;
              frame_end = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Double buffer: a transfer and an accept can never coincide since ready = !pend_v.
  always_comb begin
    pending_d = pending_q;
    pend_v_d  = pend_v_q;
    active_d  = active_q;
    if (frame_end && pend_v_q) begin
      active_d = pending_q;
      pend_v_d = 1'b0;
    end else if (load_valid && !pend_v_q) begin
      pending_d = load_data;
      pend_v_d  = 1'b1;
    end
    load_ready_d = !pend_v_d;
  end

  // Nibble select and leading-zero detection for the digit about to be shown.
  always_comb begin
    nib_sel    = 4'h0;
    sel_blank  = 1'b0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (active_d[4*k +: 4] == 4'h0);
      if (idx_d == IDX_W'(k)) begin
        nib_sel   = active_d[4*k +: 4];
        sel_blank = lz_suppress && zero_above && (k != 0);
      end
    end
  end

  seven_segment u_decode (
    .bcd_i   (nib_sel),
    .seg_c_o (dec_seg)
  );

  always_comb begin
    seg_d        = SEG_BLANK;
    digit_en_d   = '0;
    frame_done_d = frame_end;
    if (state_d == DRIVE) begin
      digit_en_d = NUM_DIGITS'(1) << idx_d;
      if (!sel_blank) seg_d = dec_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      pending_q    <= '0;
      pend_v_q     <= 1'b0;
      active_q     <= '0;
      seg_q        <= SEG_BLANK;
      digit_en_q   <= '0;
      frame_done_q <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      pend_v_q     <= pend_v_d;
      active_q     <= active_d;
      seg_q        <= seg_d;
      digit_en_q   <= digit_en_d;
      frame_done_q <= frame_done_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign seg        = seg_q;
  assign digit_en   = digit_en_q;
  assign frame_done = frame_done_q;
  assign load_ready = load_ready_q;

endmodule
